// File: rtl/bomb_stun_controller.sv
`default_nettype none
// ============================================================================
// Module      : bomb_stun_controller
// Description : Arms bombs on a 16x16 board from player requests, runs their
//               fuse and blast timers at game-tick rate, reports the live
//               explosion to the board, and stuns a victim caught in a blast
//               cross.
// Revision    : 1.0 - initial release
// ============================================================================
module bomb_stun_controller #(
    parameter int NUM_SLOTS    = 2,
    parameter int FUSE_TICKS   = 3,
    parameter int BLAST_TICKS  = 2,
    parameter int BLAST_RADIUS = 2,
    parameter int STUN_TICKS   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 bombRequested,
    input  logic [5:0]           bombX,
    input  logic [5:0]           bombY,
    input  logic [5:0]           victimX,
    input  logic [5:0]           victimY,
    output logic                 bombAccepted,
    output logic [NUM_SLOTS-1:0] bombsActive,
    output logic                 explodeValid,
    output logic [5:0]           explodeX,
    output logic [5:0]           explodeY,
    output logic                 stunnedEffect
);

    localparam int c_TIMER_MAX = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
    localparam int c_TW        = $clog2(c_TIMER_MAX + 1);
    localparam int c_SW        = $clog2(STUN_TICKS + 1);

    localparam logic [c_TW-1:0] c_FUSE_LOAD  = c_TW'(FUSE_TICKS);
    localparam logic [c_TW-1:0] c_BLAST_LOAD = c_TW'(BLAST_TICKS);
    localparam logic [c_TW-1:0] c_TIMER_ONE  = c_TW'(1);
    localparam logic [c_SW-1:0] c_STUN_LOAD  = c_SW'(STUN_TICKS);
    localparam logic [c_SW-1:0] c_STUN_ONE   = c_SW'(1);
    localparam logic [6:0]      c_RADIUS     = 7'(BLAST_RADIUS);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FUSE  = 2'd1;
    localparam logic [1:0] c_ST_BLAST = 2'd2;

    logic [1:0]           r_state [NUM_SLOTS];
    logic [3:0]           r_slotX [NUM_SLOTS];
    logic [3:0]           r_slotY [NUM_SLOTS];
    logic [c_TW-1:0]      r_timer [NUM_SLOTS];
    logic                 r_accepted;
    logic [c_SW-1:0]      r_stun;

    logic [NUM_SLOTS-1:0] w_active;
    logic [NUM_SLOTS-1:0] w_blast;
    logic [NUM_SLOTS-1:0] w_load;
    logic [NUM_SLOTS-1:0] w_slotHit;
    logic                 w_coordOk;
    logic                 w_duplicate;
    logic                 w_accept;
    logic                 w_victimOk;
    logic                 w_hit;

    // Magnitude of a difference; operands are zero-extended so no board wrap.
    function automatic logic [6:0] absDiff(input logic [6:0] a, input logic [6:0] b);
        absDiff = (a >= b) ? (a - b) : (b - a);
    endfunction

    // Per-slot occupancy flags decoded from the registered state.
    always_comb begin
        w_active = '0;
        w_blast  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_active[i] = (r_state[i] != c_ST_IDLE);
            w_blast[i]  = (r_state[i] == c_ST_BLAST);
        end
    end

    // Request qualification and choice of the lowest free slot.
    always_comb begin
        w_coordOk   = (bombX[5:4] == 2'b00) && (bombY[5:4] == 2'b00);
        w_duplicate = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_active[i] && (r_slotX[i] == bombX[3:0]) && (r_slotY[i] == bombY[3:0])) begin
                w_duplicate = 1'b1;
            end
        end
        w_accept = bombRequested && w_coordOk && !w_duplicate && !(&w_active);
        // ~a & (a+1) isolates the lowest clear bit, i.e. the lowest idle slot.
        w_load   = w_accept ? (~w_active & (w_active + NUM_SLOTS'(1))) : '0;
    end

    // Cross-shaped hit test of the victim against every live blast.
    always_comb begin
        w_victimOk = (victimX[5:4] == 2'b00) && (victimY[5:4] == 2'b00);
        w_slotHit  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_slotHit[i] = w_blast[i] && w_victimOk &&
                (((victimY[3:0] == r_slotY[i]) &&
                  (absDiff({1'b0, victimX}, {3'b000, r_slotX[i]}) <= c_RADIUS)) ||
                 ((victimX[3:0] == r_slotX[i]) &&
                  (absDiff({1'b0, victimY}, {3'b000, r_slotY[i]}) <= c_RADIUS)));
        end
        w_hit = |w_slotHit;
    end

    // Explosion report: the lowest-index blasting slot wins.
    always_comb begin
        explodeValid = |w_blast;
        explodeX     = '0;
        explodeY     = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_blast[i]) begin
                explodeX = {2'b00, r_slotX[i]};
                explodeY = {2'b00, r_slotY[i]};
            end
        end
    end

    // Slot lifecycle: IDLE -> FUSE -> BLAST -> IDLE, timers advance on tick only.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= c_ST_IDLE;
                r_slotX[i] <= '0;
                r_slotY[i] <= '0;
                r_timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                case (r_state[i])
                    c_ST_IDLE: begin
                        // A tick in the arming cycle is deliberately not applied.
                        if (w_load[i]) begin
                            r_state[i] <= c_ST_FUSE;
                            r_slotX[i] <= bombX[3:0];
                            r_slotY[i] <= bombY[3:0];
                            r_timer[i] <= c_FUSE_LOAD;
                        end
                    end
                    c_ST_FUSE: begin
                        if (tick) begin
                            if (r_timer[i] == c_TIMER_ONE) begin
                                r_state[i] <= c_ST_BLAST;
                                r_timer[i] <= c_BLAST_LOAD;
                            end else begin
                                r_timer[i] <= r_timer[i] - c_TIMER_ONE;
                            end
                        end
                    end
                    c_ST_BLAST: begin
                        if (tick) begin
                            if (r_timer[i] == c_TIMER_ONE) begin
                                r_state[i] <= c_ST_IDLE;
                                r_timer[i] <= '0;
                            end else begin
                                r_timer[i] <= r_timer[i] - c_TIMER_ONE;
                            end
                        end
                    end
                    default: begin
                        r_state[i] <= c_ST_IDLE;
                        r_timer[i] <= '0;
                    end
                endcase
            end
        end
    end

    // Acceptance strobe and shared stun counter; a hit reload beats a tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_accepted <= 1'b0;
            r_stun     <= '0;
        end else begin
            r_accepted <= w_accept;
            if (w_hit) begin
                r_stun <= c_STUN_LOAD;
            end else if (tick && (r_stun != '0)) begin
                r_stun <= r_stun - c_STUN_ONE;
            end
        end
    end

    assign bombAccepted  = r_accepted;
    assign bombsActive   = w_active;
    assign stunnedEffect = (r_stun != '0);

endmodule
`default_nettype wire

// File: tb/tb_bomb_stun_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_bomb_stun_controller
// Description : Self-checking bench for bomb_stun_controller. A reference
//               model tracks each bomb by the global tick count at arming.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bomb_stun_controller;

    localparam int NS = 2;
    localparam int FT = 3;
    localparam int BT = 2;
    localparam int BR = 2;
    localparam int ST = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          bombRequested = 1'b0;
    logic [5:0]    bombX = '0;
    logic [5:0]    bombY = '0;
    logic [5:0]    victimX = 6'd15;
    logic [5:0]    victimY = 6'd15;
    logic          bombAccepted;
    logic [NS-1:0] bombsActive;
    logic          explodeValid;
    logic [5:0]    explodeX;
    logic [5:0]    explodeY;
    logic          stunnedEffect;

    int errors = 0;
    int checks = 0;

    // Reference model: a bomb is described by where it is and the tick count
    // at which it was armed; its phase follows from elapsed ticks.
    bit mValid [NS];
    int mX [NS];
    int mY [NS];
    int mArm [NS];
    int mTicks = 0;
    int mStun = 0;
    bit mAcc = 0;

    bomb_stun_controller #(
        .NUM_SLOTS(NS), .FUSE_TICKS(FT), .BLAST_TICKS(BT),
        .BLAST_RADIUS(BR), .STUN_TICKS(ST)
    ) dut (
        .clock(clock), .reset(reset), .tick(tick),
        .bombRequested(bombRequested), .bombX(bombX), .bombY(bombY),
        .victimX(victimX), .victimY(victimY),
        .bombAccepted(bombAccepted), .bombsActive(bombsActive),
        .explodeValid(explodeValid), .explodeX(explodeX), .explodeY(explodeY),
        .stunnedEffect(stunnedEffect)
    );

    always #5 clock = ~clock;

    function automatic bit mLive(int i);
        return mValid[i] && ((mTicks - mArm[i]) < FT + BT);
    endfunction

    function automatic bit mInBlast(int i);
        return mLive(i) && ((mTicks - mArm[i]) >= FT);
    endfunction

    function automatic logic [NS-1:0] expActive();
        logic [NS-1:0] v = '0;
        for (int i = 0; i < NS; i++) v[i] = mLive(i);
        return v;
    endfunction

    function automatic int expBlastIdx();
        for (int i = 0; i < NS; i++) if (mInBlast(i)) return i;
        return -1;
    endfunction

    function automatic int absI(int v);
        return (v < 0) ? -v : v;
    endfunction

    // Advance the model by one clock edge using the inputs sampled at it.
    function automatic void modelStep(bit rst, bit req, int bx, int by, int vx, int vy, bit tk);
        int  freeSlot = -1;
        bit  dup = 0;
        bit  hit = 0;
        bit  acc;
        for (int i = 0; i < NS; i++) begin
            if (!mLive(i) && freeSlot < 0) freeSlot = i;
            if (mLive(i) && mX[i] == bx && mY[i] == by) dup = 1;
            if (mInBlast(i) && vx < 16 && vy < 16 &&
                ((vy == mY[i] && absI(vx - mX[i]) <= BR) ||
                 (vx == mX[i] && absI(vy - mY[i]) <= BR))) hit = 1;
        end
        if (rst) begin
            for (int i = 0; i < NS; i++) mValid[i] = 0;
            mStun = 0;
            mAcc  = 0;
            return;
        end
        acc = req && bx < 16 && by < 16 && freeSlot >= 0 && !dup;
        if (tk) mTicks++;
        if (acc) begin
            mValid[freeSlot] = 1;
            mX[freeSlot]     = bx;
            mY[freeSlot]     = by;
            mArm[freeSlot]   = mTicks;
        end
        if (hit) mStun = ST;
        else if (tk && mStun > 0) mStun--;
        mAcc = acc;
    endfunction

    // Drive one cycle from a negedge, let the edge happen, return at next negedge.
    task automatic drive(input bit rst, input bit req, input int bx, input int by,
                         input int vx, input int vy, input bit tk);
        reset         = rst;
        bombRequested = req;
        bombX         = 6'(bx);
        bombY         = 6'(by);
        victimX       = 6'(vx);
        victimY       = 6'(vy);
        tick          = tk;
        @(posedge clock);
        modelStep(rst, req, bx, by, vx, vy, tk);
        @(negedge clock);
    endtask

    task automatic doReset();
        drive(1, 0, 0, 0, 15, 15, 0);
        drive(1, 0, 0, 0, 15, 15, 1);
        drive(0, 0, 0, 0, 15, 15, 0);
    endtask

    task automatic test_reset();
        doReset();
        checks++; if (bombAccepted !== 1'b0) begin errors++; $display("FAIL reset_acc: got %0b want 0", bombAccepted); end
        checks++; if (bombsActive !== 2'b00) begin errors++; $display("FAIL reset_active: got %b want 00", bombsActive); end
        checks++; if (explodeValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", explodeValid); end
        checks++; if (explodeX !== 6'd0 || explodeY !== 6'd0) begin errors++; $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", explodeX, explodeY); end
        checks++; if (stunnedEffect !== 1'b0) begin errors++; $display("FAIL reset_stun: got %0b want 0", stunnedEffect); end
        for (int c = 0; c < 16; c++) begin
            drive(0, 0, 0, 0, 15, 15, (c % 4) == 3);
            checks++;
            if (bombsActive !== 2'b00 || explodeValid !== 1'b0 || stunnedEffect !== 1'b0 || bombAccepted !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet: got act=%b ev=%0b st=%0b acc=%0b want all 0", bombsActive, explodeValid, stunnedEffect, bombAccepted);
            end
        end
    endtask

    task automatic test_single_bomb();
        doReset();
        drive(0, 1, 5, 5, 15, 15, 0);
        checks++; if (bombAccepted !== 1'b1) begin errors++; $display("FAIL single_acc: got %0b want 1", bombAccepted); end
        checks++; if (bombsActive !== 2'b01) begin errors++; $display("FAIL single_active: got %b want 01", bombsActive); end
        drive(0, 0, 0, 0, 15, 15, 1);
        checks++; if (bombAccepted !== 1'b0) begin errors++; $display("FAIL single_pulse: got %0b want 0", bombAccepted); end
        drive(0, 0, 0, 0, 15, 15, 1);
        checks++; if (explodeValid !== 1'b0) begin errors++; $display("FAIL single_early: got %0b want 0", explodeValid); end
        drive(0, 0, 0, 0, 15, 15, 1);
        checks++; if (explodeValid !== 1'b1 || explodeX !== 6'd5 || explodeY !== 6'd5) begin
            errors++; $display("FAIL single_boom: got ev=%0b (%0d,%0d) want 1 (5,5)", explodeValid, explodeX, explodeY); end
        drive(0, 0, 0, 0, 15, 15, 1);
        checks++; if (explodeValid !== 1'b1) begin errors++; $display("FAIL single_hold: got %0b want 1", explodeValid); end
        drive(0, 0, 0, 0, 15, 15, 1);
        checks++; if (explodeValid !== 1'b0 || bombsActive !== 2'b00) begin
            errors++; $display("FAIL single_end: got ev=%0b act=%b want 0 00", explodeValid, bombsActive); end
    endtask

    task automatic test_capacity();
        doReset();
        drive(0, 1, 1, 1, 15, 15, 0);
        checks++; if (bombAccepted !== 1'b1) begin errors++; $display("FAIL cap_first: got %0b want 1", bombAccepted); end
        drive(0, 1, 1, 1, 15, 15, 0);
        checks++; if (bombAccepted !== 1'b0 || bombsActive !== 2'b01) begin
            errors++; $display("FAIL cap_dup: got acc=%0b act=%b want 0 01", bombAccepted, bombsActive); end
        drive(0, 1, 2, 2, 15, 15, 0);
        checks++; if (bombAccepted !== 1'b1 || bombsActive !== 2'b11) begin
            errors++; $display("FAIL cap_second: got acc=%0b act=%b want 1 11", bombAccepted, bombsActive); end
        drive(0, 1, 3, 3, 15, 15, 0);
        checks++; if (bombAccepted !== 1'b0 || bombsActive !== 2'b11) begin
            errors++; $display("FAIL cap_full: got acc=%0b act=%b want 0 11", bombAccepted, bombsActive); end
    endtask

    task automatic test_stun();
        doReset();
        drive(0, 1, 5, 5, 7, 5, 0);
        for (int t = 0; t < FT; t++) drive(0, 0, 0, 0, 7, 5, 1);
        checks++; if (stunnedEffect !== 1'b0) begin errors++; $display("FAIL stun_early: got %0b want 0", stunnedEffect); end
        drive(0, 0, 0, 0, 7, 5, 0);
        checks++; if (stunnedEffect !== 1'b1) begin errors++; $display("FAIL stun_hit: got %0b want 1", stunnedEffect); end
        drive(0, 0, 0, 0, 7, 5, 1);
        drive(0, 0, 0, 0, 7, 5, 1);
        checks++; if (explodeValid !== 1'b0) begin errors++; $display("FAIL stun_blast_end: got %0b want 0", explodeValid); end
        for (int t = 1; t <= ST; t++) begin
            drive(0, 0, 0, 0, 7, 5, 1);
            checks++;
            if (stunnedEffect !== (t < ST)) begin
                errors++; $display("FAIL stun_hold_%0d: got %0b want %0b", t, stunnedEffect, (t < ST));
            end
        end
        // Near misses: one cell beyond the arm, and diagonal.
        drive(0, 1, 5, 5, 8, 5, 0);
        for (int t = 0; t < FT; t++) drive(0, 0, 0, 0, 8, 5, 1);
        drive(0, 0, 0, 0, 8, 5, 0);
        drive(0, 0, 0, 0, 8, 5, 1);
        checks++; if (stunnedEffect !== 1'b0) begin errors++; $display("FAIL stun_miss_far: got %0b want 0", stunnedEffect); end
        drive(0, 0, 0, 0, 6, 6, 1);
        drive(0, 0, 0, 0, 6, 6, 0);
        checks++; if (stunnedEffect !== 1'b0) begin errors++; $display("FAIL stun_miss_diag: got %0b want 0", stunnedEffect); end
    endtask

    task automatic test_edge_wrap();
        doReset();
        drive(0, 1, 0, 0, 15, 0, 0);
        for (int t = 0; t < FT; t++) drive(0, 0, 0, 0, 15, 0, 1);
        drive(0, 0, 0, 0, 15, 0, 0);
        checks++; if (stunnedEffect !== 1'b0) begin errors++; $display("FAIL edge_nowrap: got %0b want 0", stunnedEffect); end
        drive(0, 0, 0, 0, 0, 2, 0);
        checks++; if (stunnedEffect !== 1'b1) begin errors++; $display("FAIL edge_armY: got %0b want 1", stunnedEffect); end
    endtask

    task automatic test_reset_midfuse();
        doReset();
        drive(0, 1, 9, 9, 9, 9, 0);
        drive(0, 0, 0, 0, 9, 9, 1);
        drive(0, 0, 0, 0, 9, 9, 1);
        drive(1, 0, 0, 0, 9, 9, 1);
        checks++; if (bombsActive !== 2'b00 || explodeValid !== 1'b0 || stunnedEffect !== 1'b0) begin
            errors++; $display("FAIL midfuse_reset: got act=%b ev=%0b st=%0b want 00 0 0", bombsActive, explodeValid, stunnedEffect); end
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 0, 0, 9, 9, 1);
            checks++; if (explodeValid !== 1'b0 || stunnedEffect !== 1'b0) begin
                errors++; $display("FAIL midfuse_after: got ev=%0b st=%0b want 0 0", explodeValid, stunnedEffect); end
        end
    endtask

    task automatic test_random();
        int bx, by, vx, vy, bi, ex, ey;
        bit req, tk, rst;
        logic [NS-1:0] eAct;
        doReset();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            req = ($urandom_range(0, 2) == 0);
            tk  = ($urandom_range(0, 1) == 1);
            bx  = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 63) : $urandom_range(0, 3);
            by  = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 63) : $urandom_range(0, 3);
            vx  = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 63) : $urandom_range(0, 6);
            vy  = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 63) : $urandom_range(0, 6);
            drive(rst, req, bx, by, vx, vy, tk);
            eAct = expActive();
            bi   = expBlastIdx();
            ex   = (bi >= 0) ? mX[bi] : 0;
            ey   = (bi >= 0) ? mY[bi] : 0;
            checks++; if (bombAccepted !== mAcc) begin errors++; $display("FAIL rnd_acc c=%0d: got %0b want %0b", c, bombAccepted, mAcc); end
            checks++; if (bombsActive !== eAct) begin errors++; $display("FAIL rnd_active c=%0d: got %b want %b", c, bombsActive, eAct); end
            checks++; if (explodeValid !== (bi >= 0)) begin errors++; $display("FAIL rnd_valid c=%0d: got %0b want %0b", c, explodeValid, (bi >= 0)); end
            checks++; if (explodeX !== 6'(ex) || explodeY !== 6'(ey)) begin
                errors++; $display("FAIL rnd_xy c=%0d: got (%0d,%0d) want (%0d,%0d)", c, explodeX, explodeY, ex, ey); end
            checks++; if (stunnedEffect !== (mStun > 0)) begin errors++; $display("FAIL rnd_stun c=%0d: got %0b want %0b", c, stunnedEffect, (mStun > 0)); end
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_single_bomb();
        test_capacity();
        test_stun();
        test_edge_wrap();
        test_reset_midfuse();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
